// File: rtl/retire_rat_if.sv
// retire_rat_if: commit inputs, free-list return bus and architectural map outputs of the retirement RAT
interface retire_rat_if #(
  parameter int RR = 2,
  parameter int PL = 6,
  parameter int IL = 6,
  parameter int FL = 6,
  parameter int INT_PRF_DEPTH = 64,
  parameter int FP_PRF_DEPTH = 64,
  parameter int ARCH_REGS = 32
);
  logic [RR-1:0] commit_valid_bus;
  logic [RR-1:0] commit_rd_valid_bus;
  logic [RR-1:0] commit_rd_type_bus;
  logic [RR*5-1:0] commit_rd_bus;
  logic [RR*PL-1:0] commit_prd_bus;
  logic [RR-1:0] write_free_we_bus;
  logic [RR-1:0] write_free_rd_type_bus;
  logic [RR*PL-1:0] write_free_prd_bus;
  logic [INT_PRF_DEPTH-1:0] int_retire_phy_map_bits;
  logic [FP_PRF_DEPTH-1:0] fp_retire_phy_map_bits;
  logic [ARCH_REGS*IL-1:0] int_arch_map_bus;
  logic [ARCH_REGS*FL-1:0] fp_arch_map_bus;
  modport master (
    output commit_valid_bus, commit_rd_valid_bus, commit_rd_type_bus, commit_rd_bus, commit_prd_bus,
    input write_free_we_bus, write_free_rd_type_bus, write_free_prd_bus,
    input int_retire_phy_map_bits, fp_retire_phy_map_bits, int_arch_map_bus, fp_arch_map_bus
  );
  modport slave (
    input commit_valid_bus, commit_rd_valid_bus, commit_rd_type_bus, commit_rd_bus, commit_prd_bus,
    output write_free_we_bus, write_free_rd_type_bus, write_free_prd_bus,
    output int_retire_phy_map_bits, fp_retire_phy_map_bits, int_arch_map_bus, fp_arch_map_bus
  );
endinterface

// File: rtl/retire_rat.sv
// retire_rat: retirement register alias table; records committed arch->phys mappings and returns displaced prds to the free list
module retire_rat #(
  parameter int RETIRE_RATE = 2,
  parameter int ARCH_REGS = 32,
  parameter int INT_PRF_DEPTH = 64,
  parameter int FP_PRF_DEPTH = 64
) (
  input logic clk,
  input logic rst_n,
  retire_rat_if.slave bus
);
  localparam int RR = RETIRE_RATE;
  localparam int IL = $clog2(INT_PRF_DEPTH);
  localparam int FL = $clog2(FP_PRF_DEPTH);
  localparam int PL = IL > FL ? IL : FL;
  logic [IL-1:0] int_map [ARCH_REGS];
  logic [IL-1:0] int_nx [ARCH_REGS];
  logic [FL-1:0] fp_map [ARCH_REGS];
  logic [FL-1:0] fp_nx [ARCH_REGS];
  logic [IL-1:0] int_new [RR];
  logic [FL-1:0] fp_new [RR];
  logic [4:0] rd [RR];
  logic [RR-1:0] eff, typ, we_nx, ty_nx, we_q, ty_q;
  logic [RR*PL-1:0] prd_nx, prd_q;
  logic [INT_PRF_DEPTH-1:0] int_bits;
  logic [FP_PRF_DEPTH-1:0] fp_bits;
  assign typ = bus.commit_rd_type_bus;
  for (genvar k = 0; k < RR; k++) begin : g_slot
    assign rd[k] = bus.commit_rd_bus[k*5+:5];
    assign int_new[k] = bus.commit_prd_bus[k*PL+:IL];
    assign fp_new[k] = bus.commit_prd_bus[k*PL+:FL];
    assign eff[k] = bus.commit_valid_bus[k] & bus.commit_rd_valid_bus[k] & (typ[k] | (rd[k] != 5'd0));
  end
  // slots walk the running map so a later slot sees an earlier slot's write to the same rd
  always_comb begin
    int_nx = int_map;
    fp_nx = fp_map;
    we_nx = eff;
    ty_nx = typ & eff;
    prd_nx = '0;
    for (int k = 0; k < RR; k++) begin
      if (eff[k] && typ[k]) begin
        prd_nx[k*PL+:PL] = PL'(fp_nx[rd[k]]);
        fp_nx[rd[k]] = fp_new[k];
      end else if (eff[k]) begin
        prd_nx[k*PL+:PL] = PL'(int_nx[rd[k]]);
        int_nx[rd[k]] = int_new[k];
      end
    end
  end
  // x0 is hardwired, so its entry never marks a physical reg as in use
  always_comb begin
    int_bits = '0;
    fp_bits = '0;
    for (int r = 0; r < ARCH_REGS; r++) begin
      if (r != 0) int_bits[int_map[r]] = 1'b1;
      fp_bits[fp_map[r]] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        int_map[r] <= IL'(r);
        fp_map[r] <= FL'(r);
      end
      we_q <= '0;
      ty_q <= '0;
      prd_q <= '0;
    end else begin
      int_map <= int_nx;
      fp_map <= fp_nx;
      we_q <= we_nx;
      ty_q <= ty_nx;
      prd_q <= prd_nx;
    end
  end
  assign bus.write_free_we_bus = we_q;
  assign bus.write_free_rd_type_bus = ty_q;
  assign bus.write_free_prd_bus = prd_q;
  assign bus.int_retire_phy_map_bits = int_bits;
  assign bus.fp_retire_phy_map_bits = fp_bits;
  for (genvar r = 0; r < ARCH_REGS; r++) begin : g_map
    assign bus.int_arch_map_bus[r*IL+:IL] = int_map[r];
    assign bus.fp_arch_map_bus[r*FL+:FL] = fp_map[r];
  end
  for (genvar k = 0; k < RR; k++) begin : g_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      eff[k] |-> !(typ[k] ? fp_bits[fp_new[k]] : int_bits[int_new[k]]));
    for (genvar j = k + 1; j < RR; j++) begin : g_pair
      assert property (@(posedge clk) disable iff (!rst_n)
        !(eff[k] && eff[j] && typ[k] == typ[j] &&
          (typ[k] ? fp_new[k] == fp_new[j] : int_new[k] == int_new[j])));
    end
  end
endmodule

// File: tb/tb_retire_rat.sv
// tb_retire_rat: directed and random commits checked against a reference map model and a free-bus scoreboard
module tb_retire_rat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [1:0] we;
    logic [1:0] ty;
    logic [11:0] prd;
  } fr_t;
  fr_t q[$];
  logic [5:0] m_int [32];
  logic [5:0] m_fp [32];
  always #5 clk = ~clk;
  retire_rat_if bus ();
  retire_rat dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_int[r] = 6'(r);
      m_fp[r] = 6'(r);
    end
  endtask
  function automatic logic is_mapped(input logic ty, input logic [5:0] p);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 32; r++)
      if (ty ? m_fp[r] == p : (r != 0 && m_int[r] == p)) hit = 1'b1;
    return hit;
  endfunction
  task automatic model_check();
    logic [191:0] im, fm;
    logic [63:0] ib, fb;
    ib = '0;
    fb = '0;
    for (int r = 0; r < 32; r++) begin
      im[r*6+:6] = m_int[r];
      fm[r*6+:6] = m_fp[r];
      if (r != 0) ib[m_int[r]] = 1'b1;
      fb[m_fp[r]] = 1'b1;
    end
    check("int_arch_map", bus.int_arch_map_bus, im);
    check("fp_arch_map", bus.fp_arch_map_bus, fm);
    check("int_map_bits", 192'(bus.int_retire_phy_map_bits), 192'(ib));
    check("fp_map_bits", 192'(bus.fp_retire_phy_map_bits), 192'(fb));
  endtask
  task automatic idle();
    bus.commit_valid_bus = '0;
    bus.commit_rd_valid_bus = '0;
    bus.commit_rd_type_bus = '0;
    bus.commit_rd_bus = '0;
    bus.commit_prd_bus = '0;
  endtask
  task automatic commit(input logic [1:0] v, input logic [1:0] rv, input logic [1:0] ty,
                        input logic [4:0] rd0, input logic [5:0] p0,
                        input logic [4:0] rd1, input logic [5:0] p1);
    fr_t e, x;
    logic [4:0] rd [2];
    logic [5:0] p [2];
    rd[0] = rd0;
    rd[1] = rd1;
    p[0] = p0;
    p[1] = p1;
    e = '0;
    bus.commit_valid_bus = v;
    bus.commit_rd_valid_bus = rv;
    bus.commit_rd_type_bus = ty;
    bus.commit_rd_bus = {rd1, rd0};
    bus.commit_prd_bus = {p1, p0};
    for (int k = 0; k < 2; k++)
      if (v[k] && rv[k] && (ty[k] || rd[k] != 5'd0)) begin
        e.we[k] = 1'b1;
        e.ty[k] = ty[k];
        if (ty[k]) begin
          e.prd[k*6+:6] = m_fp[rd[k]];
          m_fp[rd[k]] = p[k];
        end else begin
          e.prd[k*6+:6] = m_int[rd[k]];
          m_int[rd[k]] = p[k];
        end
      end
    q.push_back(e);
    @(posedge clk);
    #1;
    idle();
    x = q.pop_front();
    check("free_we", 192'(bus.write_free_we_bus), 192'(x.we));
    check("free_type", 192'(bus.write_free_rd_type_bus), 192'(x.ty));
    check("free_prd", 192'(bus.write_free_prd_bus), 192'(x.prd));
    model_check();
  endtask
  initial begin
    logic [1:0] v, rv, ty;
    logic [4:0] r0, r1;
    logic [5:0] p0, p1;
    idle();
    model_reset();
    #12;
    check("rst_int_map7", 192'(bus.int_arch_map_bus[7*6+:6]), 192'(7));
    check("rst_int_bit0", 192'(bus.int_retire_phy_map_bits[0]), 192'(0));
    check("rst_int_bit31", 192'(bus.int_retire_phy_map_bits[31]), 192'(1));
    check("rst_int_bit32", 192'(bus.int_retire_phy_map_bits[32]), 192'(0));
    check("rst_fp_bit0", 192'(bus.fp_retire_phy_map_bits[0]), 192'(1));
    check("rst_we", 192'(bus.write_free_we_bus), 192'(0));
    model_check();
    rst_n = 1'b1;
    commit(2'b01, 2'b01, 2'b00, 5'd5, 6'd40, 5'd0, 6'd0);
    check("t2_we", 192'(bus.write_free_we_bus), 192'(2'b01));
    check("t2_prd0", 192'(bus.write_free_prd_bus[5:0]), 192'(5));
    check("t2_map5", 192'(bus.int_arch_map_bus[5*6+:6]), 192'(40));
    check("t2_bit40", 192'(bus.int_retire_phy_map_bits[40]), 192'(1));
    check("t2_bit5", 192'(bus.int_retire_phy_map_bits[5]), 192'(0));
    commit(2'b11, 2'b11, 2'b00, 5'd7, 6'd41, 5'd7, 6'd42);
    check("t3_prd", 192'(bus.write_free_prd_bus), 192'({6'd41, 6'd7}));
    check("t3_map7", 192'(bus.int_arch_map_bus[7*6+:6]), 192'(42));
    check("t3_bit41", 192'(bus.int_retire_phy_map_bits[41]), 192'(0));
    check("t3_bit42", 192'(bus.int_retire_phy_map_bits[42]), 192'(1));
    commit(2'b11, 2'b11, 2'b10, 5'd0, 6'd50, 5'd3, 6'd33);
    check("t4_we", 192'(bus.write_free_we_bus), 192'(2'b10));
    check("t4_type1", 192'(bus.write_free_rd_type_bus[1]), 192'(1));
    check("t4_prd1", 192'(bus.write_free_prd_bus[11:6]), 192'(3));
    check("t4_bit50", 192'(bus.int_retire_phy_map_bits[50]), 192'(0));
    check("t4_fpmap3", 192'(bus.fp_arch_map_bus[3*6+:6]), 192'(33));
    commit(2'b11, 2'b11, 2'b10, 5'd9, 6'd44, 5'd9, 6'd45);
    check("t5_we", 192'(bus.write_free_we_bus), 192'(2'b11));
    check("t5_type", 192'(bus.write_free_rd_type_bus), 192'(2'b10));
    check("t5_prd", 192'(bus.write_free_prd_bus), 192'({6'd9, 6'd9}));
    check("t5_map9", 192'(bus.int_arch_map_bus[9*6+:6]), 192'(44));
    check("t5_fpmap9", 192'(bus.fp_arch_map_bus[9*6+:6]), 192'(45));
    commit(2'b10, 2'b01, 2'b00, 5'd12, 6'd52, 5'd13, 6'd53);
    check("noeff_we", 192'(bus.write_free_we_bus), 192'(0));
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(0, 3));
      rv = 2'($urandom_range(0, 3));
      ty = 2'($urandom_range(0, 3));
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      do p0 = 6'($urandom_range(0, 63)); while (is_mapped(ty[0], p0));
      do p1 = 6'($urandom_range(0, 63)); while (is_mapped(ty[1], p1) || (ty[1] == ty[0] && p1 == p0));
      commit(v, rv, ty, r0, p0, r1, p1);
    end
    if (is_mapped(1'b0, 6'd46)) commit(2'b01, 2'b01, 2'b00, 5'd4, 6'd0, 5'd0, 6'd0);
    commit(2'b01, 2'b01, 2'b00, 5'd4, 6'd46, 5'd0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_we", 192'(bus.write_free_we_bus), 192'(0));
    check("t6_map4", 192'(bus.int_arch_map_bus[4*6+:6]), 192'(4));
    check("t6_bit46", 192'(bus.int_retire_phy_map_bits[46]), 192'(0));
    model_check();
    #10;
    rst_n = 1'b1;
    commit(2'b01, 2'b01, 2'b01, 5'd4, 6'd46, 5'd0, 6'd0);
    check("post_rst_fp_prd", 192'(bus.write_free_prd_bus[5:0]), 192'(4));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
